// File: rtl/multi_operand_accumulator_pkg.sv
// Shared types and helpers for the multi-operand accumulator.
package multi_operand_accumulator_pkg;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  // Width of the carry counter: enough bits to count NUM_OPS carries without wrapping.
  function automatic int carry_width(input int num_ops);
    return $clog2(num_ops + 1);
  endfunction

endpackage

// File: rtl/multi_operand_accumulator_adder.sv
// N-bit ripple-carry adder, purely combinational.
module Ripple_Carry_Adder_Nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  // Bit-serial carry chain; the local carry keeps the chain out of a self-referencing vector.
  always_comb begin
    logic carry;
    s     = '0;
    carry = cin;
    for (int i = 0; i < N; i++) begin
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/multi_operand_accumulator.sv
// Accumulates NUM_OPS operands through a ripple-carry adder and presents the exact
// wide sum {carry_cnt, acc} downstream over a valid/ready handshake.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   ST_ACC | accepting operands, folding each into acc / carry_cnt
//   ST_OUT | result presented on out_sum, waiting for out_ready
module multi_operand_accumulator
  import multi_operand_accumulator_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int NUM_OPS = 4,
  localparam int CW      = carry_width(NUM_OPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N+CW-1:0] out_sum,
  output logic          busy
);

  localparam logic [CW-1:0] LAST_OP = CW'(NUM_OPS - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] carry_cnt_q, carry_cnt_d;
  logic [CW-1:0] op_cnt_q, op_cnt_d;
  logic          busy_q, busy_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [N-1:0]  add_s;
  logic          add_cout;

  Ripple_Carry_Adder_Nbit #(.N(N)) u_add (
    .x    (acc_q),
    .y    (in_data),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_cout)
  );

  // Next-state logic: handshake outputs are computed here so they come straight off flops.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_cnt_d = carry_cnt_q;
    op_cnt_d    = op_cnt_q;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid && in_ready_q) begin
          acc_d       = add_s;
          carry_cnt_d = carry_cnt_q + CW'(add_cout);
          busy_d      = 1'b1;
          if (op_cnt_q == LAST_OP) begin
            op_cnt_d    = '0;
            state_d     = ST_OUT;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            op_cnt_d = op_cnt_q + 1'b1;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          acc_d       = '0;
          carry_cnt_d = '0;
          busy_d      = 1'b0;
          state_d     = ST_ACC;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_ACC;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any partial group.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      carry_cnt_q <= '0;
      op_cnt_q    <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_cnt_q <= carry_cnt_d;
      op_cnt_q    <= op_cnt_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = {carry_cnt_q, acc_q};

endmodule

// File: tb/tb_multi_operand_accumulator.sv
// Directed and randomized checks of the multi-operand accumulator.
module tb_multi_operand_accumulator;

  logic        clk = 1'b0;
  logic        reset;

  // Default configuration: N=8, NUM_OPS=4 -> out_sum is 11 bits
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  in_data;
  logic [10:0] out_sum;

  // Single-operand configuration: N=4, NUM_OPS=1 -> out_sum is 5 bits
  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [3:0]  in_data1;
  logic [4:0]  out_sum1;

  int errors = 0;
  int checks = 0;

  multi_operand_accumulator #(.N(8), .NUM_OPS(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
  );

  multi_operand_accumulator #(.N(4), .NUM_OPS(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1), .busy(busy1)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one operand and return at the negedge following its acceptance.
  task automatic send(input logic [7:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_timeout", 16'(t < 50), 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_sum;
    logic [7:0]  d;
    int          k;

    reset = 1'b1;
    in_valid = 1'b0;  in_data = '0;  out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    idle(2);
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_out_sum", 16'(out_sum), 16'h000);
    chk("rst_in_ready1", 16'(in_ready1), 16'd1);
    chk("rst_out_sum1", 16'(out_sum1), 16'h00);

    // 1: back-to-back, in_valid held
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h01; idle(1);
    chk("b2b_busy", 16'(busy), 16'd1);
    in_data = 8'h02; idle(1);
    in_data = 8'h03; idle(1);
    chk("b2b_no_early_valid", 16'(out_valid), 16'd0);
    in_data = 8'h04; idle(1);
    in_valid = 1'b0;
    chk("b2b_valid", 16'(out_valid), 16'd1);
    chk("b2b_sum", 16'(out_sum), 16'h00A);
    chk("b2b_in_ready_low", 16'(in_ready), 16'd0);
    idle(1);
    chk("b2b_valid_one_cycle", 16'(out_valid), 16'd0);
    chk("b2b_busy_clear", 16'(busy), 16'd0);
    chk("b2b_in_ready_back", 16'(in_ready), 16'd1);

    // 2: overflow
    repeat (4) send(8'hFF);
    chk("ovf_valid", 16'(out_valid), 16'd1);
    chk("ovf_sum", 16'(out_sum), 16'h3FC);
    idle(1);
    chk("ovf_valid_drop", 16'(out_valid), 16'd0);

    // 3: gaps and backpressure, a 5th operand waits out the OUT state
    out_ready = 1'b0;
    send(8'h80); idle(1);
    send(8'h80); idle(2);
    send(8'h80); idle(3);
    send(8'h80);
    chk("bp_valid", 16'(out_valid), 16'd1);
    chk("bp_sum", 16'(out_sum), 16'h200);
    in_valid = 1'b1;
    in_data  = 8'h05;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("bp_in_ready_low", 16'(in_ready), 16'd0);
      chk("bp_valid_held", 16'(out_valid), 16'd1);
      chk("bp_sum_held", 16'(out_sum), 16'h200);
    end
    out_ready = 1'b1;
    idle(1);
    chk("bp_release_valid", 16'(out_valid), 16'd0);
    chk("bp_release_ready", 16'(in_ready), 16'd1);
    chk("bp_release_busy", 16'(busy), 16'd0);
    idle(1);
    in_valid = 1'b0;
    chk("bp_fifth_accepted", 16'(busy), 16'd1);
    repeat (3) send(8'h01);
    chk("bp_next_valid", 16'(out_valid), 16'd1);
    chk("bp_next_sum", 16'(out_sum), 16'h008);
    idle(1);
    chk("bp_next_drop", 16'(out_valid), 16'd0);

    // 4: reset mid-group
    send(8'h10);
    send(8'h20);
    chk("rmg_busy_before", 16'(busy), 16'd1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("rmg_busy_after", 16'(busy), 16'd0);
    chk("rmg_valid_after", 16'(out_valid), 16'd0);
    chk("rmg_ready_after", 16'(in_ready), 16'd1);
    chk("rmg_sum_after", 16'(out_sum), 16'h000);
    repeat (3) begin
      send(8'h01);
      chk("rmg_no_stale_result", 16'(out_valid), 16'd0);
    end
    send(8'h01);
    chk("rmg_valid", 16'(out_valid), 16'd1);
    chk("rmg_sum", 16'(out_sum), 16'h004);
    idle(1);

    // 5: NUM_OPS=1, N=4
    out_ready1 = 1'b1;
    in_valid1 = 1'b1;
    in_data1 = 4'hF;
    idle(1);
    chk("n1_valid_a", 16'(out_valid1), 16'd1);
    chk("n1_sum_a", 16'(out_sum1), 16'h0F);
    in_data1 = 4'h3;
    idle(1);
    chk("n1_gap_valid", 16'(out_valid1), 16'd0);
    chk("n1_gap_ready", 16'(in_ready1), 16'd1);
    idle(1);
    in_valid1 = 1'b0;
    chk("n1_valid_b", 16'(out_valid1), 16'd1);
    chk("n1_sum_b", 16'(out_sum1), 16'h03);
    idle(1);
    chk("n1_drop", 16'(out_valid1), 16'd0);

    // 6: random groups with random gaps and backpressure
    for (int g = 0; g < 1000; g++) begin
      exp_sum = '0;
      for (int j = 0; j < 4; j++) begin
        idle($urandom_range(0, 2));
        out_ready = 1'($urandom_range(0, 1));
        d = 8'($urandom_range(0, 255));
        exp_sum = exp_sum + 16'(d);
        send(d);
      end
      out_ready = 1'b0;
      k = $urandom_range(0, 3);
      idle(k);
      chk("rnd_valid", 16'(out_valid), 16'd1);
      chk("rnd_sum", 16'(out_sum), exp_sum);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      chk("rnd_drop", 16'(out_valid), 16'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
